spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Transaction controller directly upstream of the SPI byte engine. Accepts multi-byte transfer commands from the host, feeds the engine one byte at a time, and buffers received bytes in an RX FIFO for the host. Holds chip-select across all bytes of a command and latches SPI mode (polarity/phase) per command.

Parameters:
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
LEN_W, 4, width of cmd_len; max burst 2**LEN_W-1 bytes

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command request
cmd_ready  out  1  controller idle, can accept command
cmd_len  in  LEN_W  bytes in burst; 0 treated as no-op
cmd_mode  in  2  {polarity, phase} for this burst
tx_valid  in  1  host TX byte available
tx_ready  out  1  controller taking TX byte this cycle
tx_data  in  8  TX byte
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  host pops RX byte
rx_data  out  8  RX FIFO head byte
busy  out  1  burst in progress
cs_hold  out  1  chip-select request to engine, high for whole burst
eng_start  out  1  one-cycle start pulse to engine
eng_data_wr  out  8  byte to transmit, stable from eng_start until eng_done
eng_polarity  out  1  latched CPOL
eng_phase  out  1  latched CPHA
eng_done  in  1  one-cycle pulse, engine finished byte
eng_data_rd  in  8  received byte, valid when eng_done=1

Behaviour:
- Reset (reset=0, async): state IDLE; cmd_ready=1 after release, tx_ready=0, rx_valid=0, rx_data=0, busy=0, cs_hold=0, eng_start=0, eng_data_wr=0, eng_polarity=0, eng_phase=0; FIFO pointers and count=0; remaining count=0.
- All state registered; outputs from registers or state decode only (no combinational path from eng_done to eng_start).
- FSM states: IDLE, FETCH, ISSUE, WAIT, STORE.
- IDLE: cmd_ready=1. cmd_valid&cmd_len!=0 -> latch len into remaining, latch mode to eng_polarity/eng_phase, cs_hold=1, busy=1 -> FETCH. cmd_valid&cmd_len==0 -> accepted, stays IDLE, no activity.
- FETCH: tx_ready=1 (combinational from state). On tx_valid: eng_data_wr<=tx_data -> ISSUE. Waits indefinitely otherwise.
- ISSUE: eng_start=1 for exactly one cycle -> WAIT.
- WAIT: on eng_done: capture eng_data_rd into holding reg, remaining-=1 -> STORE. eng_done outside WAIT ignored.
- STORE: if FIFO not full: push held byte; if remaining==0 -> IDLE with cs_hold=0, busy=0 same edge; else -> FETCH. If FIFO full: stall in STORE (cs_hold stays 1) until host pops.
- Minimum per-byte overhead: FETCH(1, tx_valid pre-asserted)+ISSUE(1)+STORE(1) cycles plus engine time.
- eng_polarity/eng_phase change only at command acceptance; stable for whole burst and retained after.
- RX FIFO: standard sync FIFO, show-ahead (rx_data = head when rx_valid). Pop when rx_valid&rx_ready. Simultaneous push and pop when full: pop frees slot, push still stalls one cycle (full computed from registered count). Simultaneous push/pop when nonempty and not full: count unchanged. Pointers wrap modulo RX_DEPTH. rx_ready with empty FIFO ignored.
- cmd_valid while busy: ignored (cmd_ready=0); host must hold.
- Reset mid-burst: immediate abort, cs_hold drops asynchronously, FIFO contents lost.

Decomposition:
- Shared package spi_pkg: FSM state encoding localparams (IDLE..STORE), SPI mode constants MODE0..MODE3, byte width 8.
- One sub-module: spi_rx_fifo (params DEPTH, WIDTH=8; push/pop/full/empty/count), instantiated once.

Test Plan:
- Single byte mode 0: reset low 400 ns then high; cmd_len=1, cmd_mode=2'b00, tx_data=8'hA5; engine model returns 8'hAF -> one eng_start, eng_data_wr=8'hA5, rx_data=8'hAF, rx_valid=1, cs_hold high from accept through STORE, busy=0 after.
- Burst of 4 in each mode 2'b00/01/10/11, tx 8'h01..8'h04, engine echoes ~tx -> rx pops 8'hFE,8'hFD,8'hFC,8'hFB in order; eng_polarity/eng_phase match mode throughout; cs_hold never drops between bytes.
- FIFO full backpressure: RX_DEPTH=4, cmd_len=6, rx_ready=0 -> FSM stalls in STORE after 5th byte, cs_hold=1, exactly 5 eng_start pulses; then rx_ready=1 -> 6 bytes read in order, busy clears.
- TX starvation: tx_valid withheld 20 cycles in FETCH -> no eng_start, cs_hold held, resumes correctly when tx_valid asserted.
- cmd_len=0 and cmd_valid while busy -> no eng_start / second command not accepted until busy=0, cmd_ready=0 during burst.
- Reset asserted during WAIT of byte 2 of 3 -> all outputs to reset values asynchronously, rx_valid=0; new 1-byte command after release completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, SPI mode constants and byte width for the SPI transfer controller
package spi_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, STORE} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: host command/TX/RX handshakes plus byte-engine signals of the transfer controller
interface spi_xfer_ctrl_if #(parameter int LEN_W = 4);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [LEN_W-1:0]            cmd_len;
  logic [1:0]                  cmd_mode;
  logic                        tx_valid;
  logic                        tx_ready;
  logic [spi_pkg::BYTE_W-1:0]  tx_data;
  logic                        rx_valid;
  logic                        rx_ready;
  logic [spi_pkg::BYTE_W-1:0]  rx_data;
  logic                        busy;
  logic                        cs_hold;
  logic                        eng_start;
  logic [spi_pkg::BYTE_W-1:0]  eng_data_wr;
  logic                        eng_polarity;
  logic                        eng_phase;
  logic                        eng_done;
  logic [spi_pkg::BYTE_W-1:0]  eng_data_rd;
  modport master (
    output cmd_valid, cmd_len, cmd_mode, tx_valid, tx_data, rx_ready, eng_done, eng_data_rd,
    input  cmd_ready, tx_ready, rx_valid, rx_data, busy, cs_hold, eng_start, eng_data_wr,
           eng_polarity, eng_phase
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_mode, tx_valid, tx_data, rx_ready, eng_done, eng_data_rd,
    output cmd_ready, tx_ready, rx_valid, rx_data, busy, cs_hold, eng_start, eng_data_wr,
           eng_polarity, eng_phase
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: show-ahead synchronous FIFO buffering bytes received from the SPI engine
module spi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = empty ? '0 : mem_q[rd_q];
  // full is taken from the registered count, so a pop never frees a slot for the same-cycle push
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage, pointers and count; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sequences multi-byte host commands through the SPI byte engine, buffering RX bytes
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int LEN_W    = 4
) (
  input logic            clk,
  input logic            reset,
  spi_xfer_ctrl_if.slave bus
);
  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [1:0]          mode_q, mode_d;
  logic [BYTE_W-1:0]   wr_q, wr_d, hold_q, hold_d;
  logic                fifo_full, fifo_empty;
  assign bus.cmd_ready    = state_q == IDLE;
  assign bus.tx_ready     = state_q == FETCH;
  assign bus.eng_start    = state_q == ISSUE;
  assign bus.busy         = state_q != IDLE;
  assign bus.cs_hold      = state_q != IDLE;
  assign bus.eng_data_wr  = wr_q;
  assign bus.eng_polarity = mode_q[1];
  assign bus.eng_phase    = mode_q[0];
  assign bus.rx_valid     = !fifo_empty;
  // next state plus burst bookkeeping; zero-length commands are accepted without leaving IDLE
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    wr_d    = wr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE:  if (bus.cmd_valid && bus.cmd_len != '0) begin
        rem_d   = bus.cmd_len;
        mode_d  = bus.cmd_mode;
        state_d = FETCH;
      end
      FETCH: if (bus.tx_valid) begin
        wr_d    = bus.tx_data;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.eng_done) begin
        hold_d  = bus.eng_data_rd;
        rem_d   = rem_q - LEN_W'(1);
        state_d = STORE;
      end
      STORE: if (!fifo_full) state_d = (rem_q == '0) ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts a burst and drops cs_hold immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mode_q  <= '0;
      wr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      wr_q    <= wr_d;
      hold_q  <= hold_d;
    end
  end
  spi_rx_fifo #(.DEPTH(RX_DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (state_q == STORE),
    .pop   (bus.rx_ready),
    .wdata (hold_q),
    .rdata (bus.rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: table-driven and sequence checks of the SPI transfer controller with an engine model
module tb_spi_xfer_ctrl;
  import spi_pkg::*;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  spi_xfer_ctrl_if #(.LEN_W(4)) ifc();
  spi_xfer_ctrl #(.RX_DEPTH(4), .LEN_W(4)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  int tests = 0;
  int fails = 0;
  int n_start = 0;
  bit echo = 1;
  bit mon_cs = 0;
  logic [1:0] exp_mode = 2'b00;
  logic [7:0] eng_cap;
  logic [7:0] sb[$];
  typedef struct {
    logic [1:0] mode;
    logic [3:0] len;
    logic [7:0] tx0;
    bit         echo;
    int         starts;
    logic [1:0] pm;
    logic [7:0] wr;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    ifc.eng_done = 0;
    ifc.eng_data_rd = 0;
    forever begin
      @(negedge clk);
      ifc.eng_done = 0;
      if (ifc.eng_start === 1'b1) begin
        n_start++;
        chk("eng_mode", {ifc.eng_polarity, ifc.eng_phase}, exp_mode);
        eng_cap = ifc.eng_data_wr;
        repeat (2) @(negedge clk);
        if (reset) chk("wr_stable", ifc.eng_data_wr, eng_cap);
        ifc.eng_data_rd = echo ? ~eng_cap : 8'hAF;
        ifc.eng_done = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_cs) chk("cs_hold_burst", ifc.cs_hold, 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic feed(input int n, input logic [7:0] b0);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      ifc.tx_data = b0 + 8'(i);
      ifc.tx_valid = 1;
      while (ifc.tx_ready !== 1'b1 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) begin
        chk("tx_timeout", 0, 1);
        ifc.tx_valid = 0;
        return;
      end
      sb.push_back(echo ? ~ifc.tx_data : 8'hAF);
      @(negedge clk);
      ifc.tx_valid = 0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (ifc.busy !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < 500, 1);
  endtask

  task automatic drain(input int n);
    int t;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (ifc.rx_valid !== 1'b1 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500 || sb.size() == 0) begin
        chk("rx_timeout", 0, 1);
        return;
      end
      e = sb.pop_front();
      chk("rx_data", ifc.rx_data, e);
      ifc.rx_ready = 1;
      @(negedge clk);
      ifc.rx_ready = 0;
    end
    chk("rx_valid_after", ifc.rx_valid, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic issue_cmd(input logic [1:0] mode, input logic [3:0] len);
    ifc.cmd_mode = mode;
    ifc.cmd_len = len;
    ifc.cmd_valid = 1;
    chk("cmd_ready_idle", ifc.cmd_ready, 1);
    @(negedge clk);
    ifc.cmd_valid = 0;
    chk("busy_after_cmd", ifc.busy, len != 0);
    chk("cs_after_cmd", ifc.cs_hold, len != 0);
  endtask

  task automatic run_vec(input vec_t v);
    n_start = 0;
    echo = v.echo;
    if (v.len != 0) exp_mode = v.mode;
    issue_cmd(v.mode, v.len);
    mon_cs = v.len != 0;
    feed(int'(v.len), v.tx0);
    mon_cs = 0;
    wait_idle();
    drain(int'(v.len));
    chk("eng_starts", n_start, v.starts);
    chk("mode_latched", {ifc.eng_polarity, ifc.eng_phase}, v.pm);
    chk("eng_data_wr", ifc.eng_data_wr, v.wr);
    chk("cs_after", ifc.cs_hold, 0);
  endtask

  initial begin
    vt[0] = '{MODE0, 4'd1, 8'hA5, 1'b0, 1, MODE0, 8'hA5};
    vt[1] = '{MODE0, 4'd4, 8'h01, 1'b1, 4, MODE0, 8'h04};
    vt[2] = '{MODE1, 4'd4, 8'h01, 1'b1, 4, MODE1, 8'h04};
    vt[3] = '{MODE2, 4'd4, 8'h01, 1'b1, 4, MODE2, 8'h04};
    vt[4] = '{MODE3, 4'd4, 8'h01, 1'b1, 4, MODE3, 8'h04};
    vt[5] = '{MODE1, 4'd0, 8'h55, 1'b1, 0, MODE3, 8'h04};
    ifc.cmd_valid = 0;
    ifc.cmd_len = 0;
    ifc.cmd_mode = 0;
    ifc.tx_valid = 0;
    ifc.tx_data = 0;
    ifc.rx_ready = 0;
    #393;
    chk("rst_cmd_ready", ifc.cmd_ready, 1);
    chk("rst_tx_ready", ifc.tx_ready, 0);
    chk("rst_rx_valid", ifc.rx_valid, 0);
    chk("rst_rx_data", ifc.rx_data, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_cs_hold", ifc.cs_hold, 0);
    chk("rst_eng_start", ifc.eng_start, 0);
    chk("rst_eng_data_wr", ifc.eng_data_wr, 0);
    chk("rst_mode", {ifc.eng_polarity, ifc.eng_phase}, 0);
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) run_vec(vt[i]);
    n_start = 0;
    echo = 1;
    exp_mode = MODE1;
    issue_cmd(MODE1, 4'd6);
    mon_cs = 1;
    fork
      begin
        feed(6, 8'h10);
        mon_cs = 0;
      end
    join_none
    repeat (60) @(negedge clk);
    chk("bp_starts", n_start, 5);
    chk("bp_cs_hold", ifc.cs_hold, 1);
    chk("bp_busy", ifc.busy, 1);
    chk("bp_tx_ready", ifc.tx_ready, 0);
    chk("bp_rx_valid", ifc.rx_valid, 1);
    drain(6);
    wait fork;
    wait_idle();
    chk("bp_starts_end", n_start, 6);
    n_start = 0;
    exp_mode = MODE2;
    issue_cmd(MODE2, 4'd2);
    mon_cs = 1;
    repeat (20) @(negedge clk);
    chk("starve_starts", n_start, 0);
    chk("starve_tx_ready", ifc.tx_ready, 1);
    chk("starve_cs_hold", ifc.cs_hold, 1);
    feed(2, 8'h80);
    mon_cs = 0;
    wait_idle();
    drain(2);
    chk("starve_starts_end", n_start, 2);
    n_start = 0;
    exp_mode = MODE3;
    issue_cmd(MODE3, 4'd3);
    ifc.cmd_len = 4'd1;
    ifc.cmd_valid = 1;
    chk("busy_cmd_ready", ifc.cmd_ready, 0);
    feed(3, 8'h20);
    chk("busy_cmd_ready2", ifc.cmd_ready, 0);
    wait_idle();
    chk("busy_no_early_accept", n_start, 3);
    @(negedge clk);
    ifc.cmd_valid = 0;
    chk("second_cmd_busy", ifc.busy, 1);
    feed(1, 8'h30);
    wait_idle();
    drain(4);
    chk("second_cmd_starts", n_start, 4);
    n_start = 0;
    exp_mode = MODE2;
    issue_cmd(MODE2, 4'd3);
    feed(2, 8'h40);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("arst_cmd_ready", ifc.cmd_ready, 1);
    chk("arst_tx_ready", ifc.tx_ready, 0);
    chk("arst_rx_valid", ifc.rx_valid, 0);
    chk("arst_rx_data", ifc.rx_data, 0);
    chk("arst_busy", ifc.busy, 0);
    chk("arst_cs_hold", ifc.cs_hold, 0);
    chk("arst_eng_start", ifc.eng_start, 0);
    chk("arst_eng_data_wr", ifc.eng_data_wr, 0);
    chk("arst_mode", {ifc.eng_polarity, ifc.eng_phase}, 0);
    sb.delete();
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    exp_mode = MODE0;
    run_vec('{MODE0, 4'd1, 8'h3C, 1'b1, 1, MODE0, 8'h3C});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
